restoring_divider: RTL

Sequential shift-subtract unsigned divider: the inverse companion of the shift-add multiplier controller and datapath. It accepts a dividend and a divisor on a start pulse. It iterates one quotient bit per two clock cycles using the restoring algorithm, then presents the quotient and remainder with a one-cycle done strobe. The block sits beside the multiplier in the arithmetic unit and uses the same start/stop-style control handshake.

---
 rtl/restoring_divider_pkg.sv | 16 +
 rtl/restoring_divider_if.sv | 29 ++
 rtl/restoring_divider_datapath.sv | 92 +++++++++
 rtl/restoring_divider.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// divider_pkg: shared definitions for the restoring divider.
// Holds the FSM state encoding and the default operand width.
// Ports: none (package).
package divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    SHIFT_SUB = 3'd2,
    TEST      = 3'd3,
    DONE      = 3'd4
  } div_state_e;

endpackage

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/stop-style request and result bundle.
// Requester side (master) drives start, dividend and divisor.
// Divider side (slave) returns quotient, remainder, busy, done and div_by_zero.
interface restoring_divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_datapath.sv
// restoring_divider_datapath: A (partial remainder), Q (dividend/quotient)
// and M (divisor) registers with one WIDTH+1-bit adder/subtractor.
// Ports:
//   Clk, reset         clock, asynchronous active-high reset
//   load               A<-0, Q<-dividend, M<-divisor
//   shift_sub          shift {A,Q} left by one, then A <- A - M
//   test_restore       restore A when negative and set Q[0] accordingly
//   dividend, divisor  operands, sampled only on load
//   a_sign             sign bit of the registered A
//   q_next, r_next     next-cycle Q and A[WIDTH-1:0], used by the top to
//                      capture results on the same edge as the final step
module restoring_divider_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_sub,
  input  logic             test_restore,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             a_sign,
  output logic [WIDTH-1:0] q_next,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;

  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   a_shift_s;
  logic [WIDTH:0]   op_a_s;
  logic [WIDTH:0]   addend_s;
  logic [WIDTH:0]   sum_s;

  // Shared adder: subtracts M from shifted A, or adds M back to A on restore.
  always_comb begin
    m_ext_s   = {1'b0, m_q};
    a_shift_s = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    op_a_s    = shift_sub ? a_shift_s : a_q;
    addend_s  = shift_sub ? ~m_ext_s : m_ext_s;
    sum_s     = op_a_s + addend_s + {{WIDTH{1'b0}}, shift_sub};
  end

  // Next-state selection for A, Q and M.
  always_comb begin
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    if (load) begin
      a_d = {(WIDTH+1){1'b0}};
      q_d = dividend;
      m_d = divisor;
    end else if (shift_sub) begin
      a_d = sum_s;
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else if (test_restore) begin
      if (a_q[WIDTH]) begin
        a_d    = sum_s;
        q_d[0] = 1'b0;
      end else begin
        a_d    = a_q;
        q_d[0] = 1'b1;
      end
    end else begin
      a_d = a_q;
      q_d = q_q;
      m_d = m_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      a_q <= {(WIDTH+1){1'b0}};
      q_q <= {WIDTH{1'b0}};
      m_q <= {WIDTH{1'b0}};
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
    end
  end

  assign a_sign = a_q[WIDTH];
  assign q_next = q_d;
  assign r_next = a_d[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential restoring unsigned divider, one quotient
// bit every two cycles (SHIFT_SUB then TEST).
// Ports:
//   Clk    clock, rising edge
//   reset  asynchronous, active-high; returns to IDLE with outputs cleared
//   bus    restoring_divider_if.slave: start/dividend/divisor in,
//          quotient/remainder/busy/done/div_by_zero out (all registered)
// Build option: define DIV_ZERO_DETECT_EN to short-circuit a zero divisor
// from INIT straight to DONE with div_by_zero set; otherwise the full
// algorithm runs and div_by_zero is tied low.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                Clk,
  input  logic                reset,
  restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  logic             load_s;
  logic             shift_sub_s;
  logic             test_restore_s;
  logic             a_sign_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] r_next_s;

  restoring_divider_datapath #(.WIDTH(WIDTH)) u_datapath (
    .Clk          (Clk),
    .reset        (reset),
    .load         (load_s),
    .shift_sub    (shift_sub_s),
    .test_restore (test_restore_s),
    .dividend     (bus.dividend),
    .divisor      (bus.divisor),
    .a_sign       (a_sign_s),
    .q_next       (q_next_s),
    .r_next       (r_next_s)
  );

  // FSM next state, datapath controls and next values of the output registers.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    quot_d         = quot_q;
    rem_d          = rem_q;
    load_s         = 1'b0;
    shift_sub_s    = 1'b0;
    test_restore_s = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d          = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = INIT;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        load_s  = 1'b1;
        count_d = {CW{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
        dbz_d   = 1'b0;
        if (bus.divisor == {WIDTH{1'b0}}) begin
          state_d = DONE;
          quot_d  = {WIDTH{1'b1}};
          rem_d   = bus.dividend;
          dbz_d   = 1'b1;
        end else begin
          state_d = SHIFT_SUB;
        end
`else
        state_d = SHIFT_SUB;
`endif
      end
      SHIFT_SUB: begin
        shift_sub_s = 1'b1;
        state_d     = TEST;
      end
      TEST: begin
        test_restore_s = 1'b1;
        count_d        = count_q + {{(CW-1){1'b0}}, 1'b1};
        // Results are captured from the datapath's next values so they
        // appear together with done.
        if (count_d == COUNT_LAST) begin
          state_d = DONE;
          quot_d  = q_next_s;
          rem_d   = r_next_s;
        end else begin
          state_d = SHIFT_SUB;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == INIT) || (state_d == SHIFT_SUB) || (state_d == TEST);
    done_d = (state_d == DONE);
  end

  // FSM, iteration counter and registered outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // a_sign_s is consumed inside the datapath's restore decision; the top
  // only sequences the steps.
  logic unused_s;
  assign unused_s = a_sign_s;

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule
